ram_ctrl: RTL and testbench
===========================

# ram_ctrl

Request/response front-end that sits directly upstream of the 64x8 synchronous RAM (SmallRam). It accepts single read/write commands over a valid/ready handshake and drives the RAM's Address/WR/CS/Di pins from registers. It absorbs the RAM's one-cycle registered read latency and its CS-gated output, and returns read data over a valid/ready response channel. One command is outstanding at a time.

## Interface
- ADDR_W, 6, RAM address width; must match the RAM (depth = 2^ADDR_W = 64)
- DATA_W, 8, data width
- Clk  in  1  clock; all state changes on rising edge
- Rst_n  in  1  reset, synchronous, active-low
- ReqValid  in  1  command valid
- ReqReady  out  1  controller can accept a command
- ReqWr  in  1  1 = write, 0 = read
- ReqAddr  in  ADDR_W  command address
- ReqData  in  DATA_W  write data (ignored for reads)
- RspValid  out  1  read data valid
- RspReady  in  1  consumer takes read data
- RspData  out  DATA_W  read data
- MemAddr  out  ADDR_W  to RAM Address
- MemWR  out  1  to RAM WR
- MemCS  out  1  to RAM CS
- MemDi  out  DATA_W  to RAM Di
- MemDo  in  DATA_W  from RAM Do (reads 0 whenever MemCS = 0)

## Operation
- FSM states: CLEAR (only with macro), IDLE, WRITE, READ, CAPT, RESP.
- IDLE: ReqReady = 1. On ReqValid & ReqReady, latch ReqAddr/ReqData, then go to WRITE if ReqWr = 1, otherwise go to READ.
- WRITE: MemCS = 1, MemWR = 1, MemAddr/MemDi = latched values. The RAM stores the data at the end of this cycle. Next state is IDLE. Writes produce no response.
- READ: MemCS = 1, MemWR = 0. The RAM registers the array word at the end of this cycle. Next state is CAPT.
- CAPT: MemCS = 1, MemWR = 0. MemDo is sampled into RspData at the end of this cycle. Next state is RESP.
- RESP: RspValid = 1, MemCS = 0. RspData is held stable until RspValid & RspReady, then the FSM goes to IDLE. RspReady is ignored outside RESP.
- ReqReady = 1 only in IDLE. A ReqValid seen in any other state is not accepted and must be held by the requester.
- MemCS = 0 and MemWR = 0 in IDLE and RESP.
- All Mem* outputs come from the state register and latch registers only. There is no combinational path from Req* to Mem*.
- Reset (Rst_n = 0 at an edge) aborts any state. The next state is CLEAR (with macro) or IDLE.
- Reset mid-read drops the pending response; RspValid = 0 on the following cycle.
- RAM contents are not reset by this block.

## Timing
- Reset values: RspValid 0, RspData 0, MemCS 0, MemWR 0, MemAddr 0, MemDi 0.
- ReqReady after reset: 1 (IDLE) without the macro; 0 (CLEAR) with it.
- Write: handshake at edge N; MemCS/MemWR high during cycle N..N+1; array updated at edge N+1; ReqReady = 1 again after edge N+1. Maximum write rate is 1 per 2 cycles.
- Read: handshake at edge N; READ spans N..N+1; CAPT spans N+1..N+2; RspValid = 1 from edge N+2. Latency is 2 cycles to RspValid, and a zero-wait read occupies 3 cycles.
- Read immediately following a write to the same address: the write lands at N+1 and the read array access occurs at N+3, so the new data is returned.
- Backpressure: RspReady held low keeps the FSM in RESP indefinitely with RspData unchanged.

## Configuration
- RAM_CTRL_CLEAR_EN defined:
  - After every reset the FSM enters CLEAR.
  - MemCS = 1, MemWR = 1, MemDi = 0, and MemAddr counts 0, 1, ... 63, one address per cycle.
  - After writing address 63 the counter wraps to 0 and the FSM goes to IDLE.
  - ReqReady = 0 for all 64 CLEAR cycles.
  - Reset during CLEAR restarts the sweep at address 0.
- RAM_CTRL_CLEAR_EN undefined: no CLEAR state and no sweep counter; reset goes straight to IDLE.

## Structure
- Package ram_ctrl_pkg: state enum (CLEAR, IDLE, WRITE, READ, CAPT, RESP) and default ADDR_W = 6 and DATA_W = 8 constants.
- Single flat module; no sub-module is warranted. The clear sweep counter lives inside ram_ctrl under the macro.
- The bench top instantiates ram_ctrl wired to SmallRam.

## Test plan
- Write 0xA5 to address 0x05, then read 0x05: RspValid rises 2 cycles after the read handshake with RspData = 0xA5; MemCS = 0 in RESP.
- Back-to-back writes to 0x00..0x3F with data equal to the address, then read 0x3F and 0x00: returns 0x3F and 0x00; ReqReady toggles 1/0 every cycle during the writes.
- Read with RspReady held low for 5 cycles: RspValid and RspData are stable throughout; ReqValid held high is not accepted until the cycle after RspReady = 1.
- Rst_n = 0 during CAPT: RspValid stays 0 and no response is ever produced; the next read of the same address returns the correct data.
- With RAM_CTRL_CLEAR_EN: preload 0xFF at 0x10, then reset. ReqReady = 0 for exactly 64 cycles with MemAddr sweeping 0..63; a subsequent read of 0x10 returns 0x00.
- Without RAM_CTRL_CLEAR_EN: ReqReady = 1 on the first cycle after reset release, and preloaded data survives the reset.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the ram_ctrl front-end.
// RAM_CTRL_CLEAR_EN selects CLEAR as the reset state (zero sweep after reset).
package ram_ctrl_pkg;

   localparam int RAM_ADDR_W = 6;
   localparam int RAM_DATA_W = 8;

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_WRITE,
      S_READ,
      S_CAPT,
      S_RESP
   } state_t;

`ifdef RAM_CTRL_CLEAR_EN
   localparam state_t RESET_STATE = S_CLEAR;
`else
   localparam state_t RESET_STATE = S_IDLE;
`endif

   // States in which the RAM chip select is asserted.
   function automatic logic drives_cs(state_t s);
      return (s == S_CLEAR) || (s == S_WRITE) || (s == S_READ) || (s == S_CAPT);
   endfunction

   // States in which the RAM write enable is asserted.
   function automatic logic drives_wr(state_t s);
      return (s == S_CLEAR) || (s == S_WRITE);
   endfunction

endpackage

// File: rtl/ram_ctrl.sv
// Single-outstanding request/response front-end for the 64x8 SmallRam.
// Optional RAM_CTRL_CLEAR_EN: zero the whole RAM with a sweep after every reset.
module ram_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic              ReqWr,
   input  logic [ADDR_W-1:0] ReqAddr,
   input  logic [DATA_W-1:0] ReqData,
   output logic              RspValid,
   input  logic              RspReady,
   output logic [DATA_W-1:0] RspData,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              MemWR,
   output logic              MemCS,
   output logic [DATA_W-1:0] MemDi,
   input  logic [DATA_W-1:0] MemDo
);

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              accept;

   assign accept = ReqValid && (state_q == S_IDLE);

   // Command latches feed the Mem* pins, so requesters never see a
   // combinational path into the RAM.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q    <= RESET_STATE;
         addr_q     <= '0;
         data_q     <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q <= ReqAddr;
            data_q <= ReqData;
         end
         if (state_q == S_CAPT) begin
            rsp_data_q <= MemDo;
         end
      end
   end

`ifdef RAM_CTRL_CLEAR_EN
   logic [ADDR_W-1:0] clr_cnt;
   logic              clr_last;

   assign clr_last = (clr_cnt == {ADDR_W{1'b1}});

   // Sweep address wraps back to zero naturally after the last word.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         clr_cnt <= '0;
      end else if (state_q == S_CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
`ifdef RAM_CTRL_CLEAR_EN
         S_CLEAR: begin
            if (clr_last) begin
               state_d = S_IDLE;
            end
         end
`endif
         S_IDLE: begin
            if (ReqValid) begin
               state_d = ReqWr ? S_WRITE : S_READ;
            end
         end
         S_WRITE: state_d = S_IDLE;
         S_READ:  state_d = S_CAPT;
         // RAM output is registered and CS-gated, so CS stays high here.
         S_CAPT:  state_d = S_RESP;
         S_RESP: begin
            if (RspReady) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ReqReady = (state_q == S_IDLE);
      RspValid = (state_q == S_RESP);
      RspData  = rsp_data_q;
      MemCS    = drives_cs(state_q);
      MemWR    = drives_wr(state_q);
      MemAddr  = addr_q;
      MemDi    = data_q;
`ifdef RAM_CTRL_CLEAR_EN
      if (state_q == S_CLEAR) begin
         MemAddr = clr_cnt;
         MemDi   = '0;
      end
`endif
   end

endmodule

// File: tb/tb_ram_ctrl.sv
// Randomised bench for ram_ctrl wired to a SmallRam model, checked against a
// transaction-level reference (build with RAM_CTRL_CLEAR_EN to cover the sweep).
module tb_ram_ctrl;
   import ram_ctrl_pkg::*;

   localparam int AW    = RAM_ADDR_W;
   localparam int DW    = RAM_DATA_W;
   localparam int DEPTH = 1 << AW;

   logic          Clk      = 1'b0;
   logic          Rst_n    = 1'b0;
   logic          ReqValid = 1'b0;
   logic          ReqWr    = 1'b0;
   logic [AW-1:0] ReqAddr  = '0;
   logic [DW-1:0] ReqData  = '0;
   logic          RspReady = 1'b1;
   logic          ReqReady;
   logic          RspValid;
   logic [DW-1:0] RspData;
   logic [AW-1:0] MemAddr;
   logic          MemWR;
   logic          MemCS;
   logic [DW-1:0] MemDi;
   logic [DW-1:0] MemDo;

   int vectors     = 0;
   int miscompares = 0;
   int rr_mode     = 0;

   always #5 Clk = ~Clk;

   ram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWr(ReqWr),
      .ReqAddr(ReqAddr), .ReqData(ReqData),
      .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData),
      .MemAddr(MemAddr), .MemWR(MemWR), .MemCS(MemCS), .MemDi(MemDi),
      .MemDo(MemDo)
   );

   // SmallRam: synchronous 64x8, registered read, output forced to 0 when CS low.
   logic [DW-1:0] ram [DEPTH] = '{default: '0};
   logic [DW-1:0] ram_q = '0;
   always @(posedge Clk) begin
      if (MemCS) begin
         if (MemWR) ram[MemAddr] <= MemDi;
         else       ram_q <= ram[MemAddr];
      end
   end
   assign MemDo = MemCS ? ram_q : '0;

   // Reference: memory image plus busy-cycle counts taken from the timing rules.
   logic [DW-1:0] ref_mem [DEPTH] = '{default: '0};
   int            wr_left    = 0;
   int            rd_left    = 0;
   int            clear_left = 0;
   bit            rsp_pend   = 1'b0;
   bit            started    = 1'b0;
   logic [AW-1:0] m_addr     = '0;
   logic [AW-1:0] clear_addr = '0;
   logic [DW-1:0] m_data     = '0;
   logic [DW-1:0] m_rsp      = '0;

   always @(posedge Clk) begin
      started = 1'b1;
      if (!Rst_n) begin
         wr_left    = 0;
         rd_left    = 0;
         rsp_pend   = 1'b0;
         m_addr     = '0;
         m_data     = '0;
         m_rsp      = '0;
         clear_addr = '0;
`ifdef RAM_CTRL_CLEAR_EN
         clear_left = DEPTH;
`else
         clear_left = 0;
`endif
      end else if (clear_left > 0) begin
         ref_mem[clear_addr] = '0;
         clear_addr = clear_addr + 1'b1;
         clear_left--;
      end else if (wr_left > 0) begin
         ref_mem[m_addr] = m_data;
         wr_left--;
      end else if (rd_left > 0) begin
         rd_left--;
         if (rd_left == 0) begin
            m_rsp    = ref_mem[m_addr];
            rsp_pend = 1'b1;
         end
      end else if (rsp_pend) begin
         if (RspReady) rsp_pend = 1'b0;
      end else if (ReqValid) begin
         m_addr = ReqAddr;
         m_data = ReqData;
         if (ReqWr) wr_left = 1;
         else       rd_left = 2;
      end
   end

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the reference, away from the active edge.
   always @(negedge Clk) begin
      if (started) begin
         logic exp_cs;
         logic exp_wr;
         exp_cs = (clear_left > 0) || (wr_left > 0) || (rd_left > 0);
         exp_wr = (clear_left > 0) || (wr_left > 0);
         check_output("ReqReady", 32'(ReqReady),
                      32'(exp_cs == 1'b0 && !rsp_pend));
         check_output("RspValid", 32'(RspValid), 32'(rsp_pend));
         check_output("RspData", 32'(RspData), 32'(m_rsp));
         check_output("MemCS", 32'(MemCS), 32'(exp_cs));
         check_output("MemWR", 32'(MemWR), 32'(exp_wr));
         if (exp_cs) begin
            check_output("MemAddr", 32'(MemAddr),
                         32'((clear_left > 0) ? clear_addr : m_addr));
            check_output("MemDi", 32'(MemDi),
                         32'((clear_left > 0) ? '0 : m_data));
         end
      end
   end

   // Response-side backpressure driver, changing mid-cycle.
   always @(posedge Clk) begin
      #2;
      if (rr_mode == 0)      RspReady = 1'b1;
      else if (rr_mode == 1) RspReady = ($urandom_range(0, 3) != 0);
   end

   // Present a command and hold it until accepted; leaves ReqValid high.
   task automatic apply_stimulus(input bit wr, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d);
      bit ok;
      ok       = 1'b0;
      ReqValid = 1'b1;
      ReqWr    = wr;
      ReqAddr  = a;
      ReqData  = d;
      for (int n = 0; n < 300; n++) begin
         if (ReqReady) begin
            @(posedge Clk);
            ok = 1'b1;
            break;
         end
         @(negedge Clk);
      end
      if (!ok) check_output("req_accept_timeout", 32'd0, 32'd1);
      @(negedge Clk);
   endtask

   task automatic wait_rsp(input bit check_data, input logic [DW-1:0] exp);
      int n;
      n = 0;
      while (!RspValid && n < 300) begin
         @(negedge Clk);
         n++;
      end
      if (!RspValid) check_output("rsp_timeout", 32'd0, 32'd1);
      else if (check_data) check_output("rsp_data_lit", 32'(RspData), 32'(exp));
      for (int k = 0; k < 300; k++) begin
         if (RspValid && RspReady) begin
            @(negedge Clk);
            break;
         end
         @(negedge Clk);
      end
   endtask

   task automatic read_expect(input logic [AW-1:0] a, input logic [DW-1:0] exp);
      int n;
      apply_stimulus(1'b0, a, '0);
      ReqValid = 1'b0;
      n = 1;
      while (!RspValid && n < 50) begin
         @(negedge Clk);
         n++;
      end
      check_output("read_latency", 32'(n), 32'd3);
      check_output("resp_cs_low", 32'(MemCS), 32'd0);
      wait_rsp(1'b1, exp);
   endtask

   task automatic do_reset();
      ReqValid = 1'b0;
      Rst_n    = 1'b0;
      @(negedge Clk);
      Rst_n    = 1'b1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [DW-1:0] held;
      int            n;
      bit            wr;

      repeat (2) @(negedge Clk);
`ifdef RAM_CTRL_CLEAR_EN
      check_output("reset_cs", 32'(MemCS), 32'd1);
      check_output("reset_ready", 32'(ReqReady), 32'd0);
`else
      check_output("reset_cs", 32'(MemCS), 32'd0);
      check_output("reset_wr", 32'(MemWR), 32'd0);
      check_output("reset_ready", 32'(ReqReady), 32'd1);
      check_output("reset_di", 32'(MemDi), 32'd0);
`endif
      check_output("reset_addr", 32'(MemAddr), 32'd0);
      check_output("reset_rspvalid", 32'(RspValid), 32'd0);
      check_output("reset_rspdata", 32'(RspData), 32'd0);
      Rst_n = 1'b1;
      n = 0;
      while (!ReqReady && n < 200) begin
         @(negedge Clk);
         n++;
      end

      // Write then read back one word.
      apply_stimulus(1'b1, 6'h05, 8'hA5);
      ReqValid = 1'b0;
      read_expect(6'h05, 8'hA5);

      // Back-to-back writes, data equal to address.
      for (int i = 0; i < DEPTH; i++) begin
         apply_stimulus(1'b1, AW'(i), DW'(i));
      end
      ReqValid = 1'b0;
      @(negedge Clk);
      read_expect(6'h3F, 8'h3F);
      read_expect(6'h00, 8'h00);

      // Response backpressure with a second read waiting.
      rr_mode  = 2;
      RspReady = 1'b0;
      apply_stimulus(1'b0, 6'h2A, '0);
      ReqAddr = 6'h15;
      n = 0;
      while (!RspValid && n < 20) begin
         @(negedge Clk);
         n++;
      end
      held = RspData;
      check_output("bp_data_lit", 32'(held), 32'h2A);
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         check_output("bp_valid_held", 32'(RspValid), 32'd1);
         check_output("bp_data_held", 32'(RspData), 32'(held));
      end
      RspReady = 1'b1;
      rr_mode  = 0;
      @(negedge Clk);
      check_output("bp_not_yet_ready", 32'(ReqReady), 32'd1);
      apply_stimulus(1'b0, 6'h15, '0);
      ReqValid = 1'b0;
      wait_rsp(1'b1, 8'h15);

      // Reset while the read is in its capture cycle.
      apply_stimulus(1'b0, 6'h07, '0);
      ReqValid = 1'b0;
      @(negedge Clk);
      do_reset();
      for (int i = 0; i < 5; i++) begin
         check_output("abort_no_rsp", 32'(RspValid), 32'd0);
         @(negedge Clk);
      end
      n = 0;
      while (!ReqReady && n < 200) begin
         @(negedge Clk);
         n++;
      end
`ifdef RAM_CTRL_CLEAR_EN
      read_expect(6'h07, 8'h00);
`else
      read_expect(6'h07, 8'h07);
`endif

      // Preloaded data across a reset.
      apply_stimulus(1'b1, 6'h10, 8'hFF);
      ReqValid = 1'b0;
      @(negedge Clk);
      do_reset();
      n = 0;
      while (!ReqReady && n < 200) begin
         @(negedge Clk);
         n++;
      end
`ifdef RAM_CTRL_CLEAR_EN
      check_output("clear_busy_cycles", 32'(n), 32'd64);
      read_expect(6'h10, 8'h00);
`else
      check_output("ready_after_reset", 32'(n), 32'd0);
      read_expect(6'h10, 8'hFF);
`endif

      // Random traffic with random response backpressure.
      rr_mode = 1;
      for (int t = 0; t < 400; t++) begin
         wr = ($urandom_range(0, 1) == 1);
         apply_stimulus(wr, AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            ReqValid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge Clk);
         end
      end
      ReqValid = 1'b0;
      rr_mode  = 0;
      repeat (10) @(negedge Clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
